// File: rtl/ich_acc_ctrl.sv
// ich_acc_ctrl: sequencing and accumulation control for a 3-stage adder tree.
// A job produces cfg_out_num results. Each result is the sum of cfg_grp_num
// 32-channel groups. One group is pushed into the tree per accepted in_valid.
// A 3-deep tag pipe follows each group through the tree. At the tree output,
// tree_psum is folded into an accumulator, and on the last group of a result
// the sum is presented on out_psum.
//
// state | meaning
// IDLE  | waiting for start; config latched when start is seen
// RUN   | issuing groups into the tree
// DRAIN | all groups issued; waiting for the tag pipe and output to empty
// DONE  | one-cycle end-of-job state; done pulses here
module ich_acc_ctrl #(
  parameter int PSUM_WIDTH = 32,
  parameter int GRP_W      = 6,
  parameter int OUT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [GRP_W-1:0]      cfg_grp_num,
  input  logic [OUT_W-1:0]      cfg_out_num,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  pipe_en,
  input  logic [PSUM_WIDTH-1:0] tree_psum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PSUM_WIDTH-1:0] out_psum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;

  // Latched config, stored as "count - 1" so the terminal compare is direct.
  logic [GRP_W-1:0]      grp_last_q;
  logic [OUT_W-1:0]      out_last_q;
  logic [GRP_W-1:0]      grp_last_d;
  logic [OUT_W-1:0]      out_last_d;

  logic [GRP_W-1:0]      grp_cnt_q;
  logic [OUT_W-1:0]      out_cnt_q;

  logic [2:0]            vld_q;
  logic [2:0]            first_q;
  logic [2:0]            last_q;

  logic [PSUM_WIDTH-1:0] acc_q;
  logic [PSUM_WIDTH-1:0] acc_sum_d;
  logic [PSUM_WIDTH-1:0] out_psum_q;
  logic                  out_valid_q;

  logic                  active;
  logic                  stall;
  logic                  pipe_en_d;
  logic                  fire;
  logic                  grp_wrap;
  logic                  out_final;
  logic                  consume;
  logic                  drain_exit;
  logic                  launch;

  // Config latch values; a group count of zero behaves like one.
  always_comb begin
    grp_last_d = '0;
    if (cfg_grp_num != '0) begin
      grp_last_d = cfg_grp_num - GRP_W'(1);
    end
    out_last_d = cfg_out_num - OUT_W'(1);
  end

  // Handshake, stall and pipeline-enable decode.
  always_comb begin
    active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    stall      = out_valid_q && !out_ready;
    pipe_en_d  = active && !stall;
    fire       = in_valid && (state_q == S_RUN) && pipe_en_d;
    grp_wrap   = (grp_cnt_q == grp_last_q);
    out_final  = (out_cnt_q == out_last_q);
    consume    = vld_q[2] && pipe_en_d;
    acc_sum_d  = (first_q[2] ? '0 : acc_q) + tree_psum;
    drain_exit = (vld_q == 3'b000) && (!out_valid_q || out_ready);
    launch     = (state_q == S_IDLE) && start && (cfg_out_num != '0);
  end

  // Job FSM with registered busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      grp_last_q <= '0;
      out_last_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            grp_last_q <= grp_last_d;
            out_last_q <= out_last_d;
            if (cfg_out_num != '0) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (fire && grp_wrap && out_final) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_exit) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Issue counters: group index within a result, and result index within the job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_cnt_q <= '0;
      out_cnt_q <= '0;
    end else if (launch) begin
      grp_cnt_q <= '0;
      out_cnt_q <= '0;
    end else if (fire) begin
      if (grp_wrap) begin
        grp_cnt_q <= '0;
        out_cnt_q <= out_cnt_q + OUT_W'(1);
      end else begin
        grp_cnt_q <= grp_cnt_q + GRP_W'(1);
      end
    end
  end

  // Tag pipe tracking each group through the three tree stages.
  // It shifts in lockstep with the tree; a cycle with no accept inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (pipe_en_d) begin
      vld_q   <= {vld_q[1:0],   fire};
      first_q <= {first_q[1:0], fire && (grp_cnt_q == '0)};
      last_q  <= {last_q[1:0],  fire && grp_wrap};
    end
  end

  // Running accumulator. The first tag restarts the sum so results never bleed together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (consume) begin
      acc_q <= acc_sum_d;
    end
  end

  // Result register. Consume only happens when not stalled, so a held result is never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_psum_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (consume && last_q[2]) begin
      out_psum_q  <= acc_sum_d;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pipe_en   = pipe_en_d;
  assign in_ready  = (state_q == S_RUN) && pipe_en_d;
  assign out_valid = out_valid_q;
  assign out_psum  = out_psum_q;

endmodule

// File: tb/tb_ich_acc_ctrl.sv
// Bench for ich_acc_ctrl: models the external 3-stage adder tree and keeps a
// reference of the expected result sums, built from the accepted group values.
module tb_ich_acc_ctrl;
  localparam int PW = 32;
  localparam int GW = 6;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [GW-1:0] cfg_grp_num;
  logic [OW-1:0] cfg_out_num;
  logic          busy, done, in_valid, in_ready, pipe_en, out_valid, out_ready;
  logic [PW-1:0] tree_psum, out_psum, grp_data;
  logic [PW-1:0] t1, t2, t3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] vals[$];
  logic [PW-1:0] cur_sum;
  logic [PW-1:0] first_res, last_res;
  int cur_n, grp_eff, sent, results, done_cnt, done_cyc;
  int fire_first, ov_first, inrdy_cnt, stall_cyc, start_cyc;

  always #5 clk = ~clk;

  ich_acc_ctrl #(.PSUM_WIDTH(PW), .GRP_W(GW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_grp_num(cfg_grp_num),
    .cfg_out_num(cfg_out_num), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .pipe_en(pipe_en),
    .tree_psum(tree_psum), .out_valid(out_valid), .out_ready(out_ready),
    .out_psum(out_psum)
  );

  // External adder tree: three registers all gated by pipe_en.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t1 <= '0; t2 <= '0; t3 <= '0;
    end else if (pipe_en) begin
      t1 <= grp_data; t2 <= t1; t3 <= t2;
    end
  end
  assign tree_psum = t3;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(int g);
    grp_eff = (g == 0) ? 1 : g;
    exp_q.delete();
    cur_sum = '0; cur_n = 0; sent = 0; results = 0; done_cnt = 0; done_cyc = -1;
    fire_first = -1; ov_first = -1; inrdy_cnt = 0; stall_cyc = 0;
    first_res = '0; last_res = '0;
  endtask

  // Observe one cycle at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (in_ready) inrdy_cnt++;
    if (in_valid && in_ready) begin
      if (fire_first < 0) fire_first = cyc;
      sent++;
      cur_sum = cur_sum + grp_data;
      cur_n++;
      if (cur_n == grp_eff) begin
        exp_q.push_back(cur_sum);
        cur_sum = '0;
        cur_n = 0;
      end
    end
    if (out_valid) begin
      if (ov_first < 0) ov_first = cyc;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $error("FAIL unexpected_result observed=%0h expected=none", out_psum);
      end else begin
        chk("out_psum", out_psum, exp_q[0]);
      end
      if (!out_ready) begin
        stall_cyc++;
        chk("stall_pipe_en", pipe_en, 0);
        chk("stall_in_ready", in_ready, 0);
      end else begin
        if (results == 0) first_res = out_psum;
        last_res = out_psum;
        results++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_job(int g, int o, bit rnd_in, bit rnd_rdy, int hold);
    int budget;
    int ngrp;
    int hold_left;
    hold_left = hold;
    model_clear(g);
    ngrp = grp_eff * o;
    for (int i = vals.size(); i < ngrp; i++) vals.push_back($urandom);
    start = 1'b1;
    cfg_grp_num = GW'(g);
    cfg_out_num = OW'(o);
    start_cyc = cyc;
    tick();
    start = 1'b0;
    budget = 0;
    while (done_cnt == 0 && budget < 600) begin
      cfg_grp_num = GW'($urandom);
      cfg_out_num = OW'($urandom);
      start     = rnd_in && ($urandom_range(0, 3) == 0);
      in_valid  = (sent < ngrp) && (rnd_in ? ($urandom_range(0, 1) == 1) : 1'b1);
      grp_data  = (sent < ngrp) ? vals[sent] : PW'($urandom);
      out_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid && results == 0 && hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end
      tick();
      budget++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", done_cnt, 1);
    chk("result_count", results, o);
    chk("groups_sent", sent, ngrp);
    chk("results_pending", exp_q.size(), 0);
    tick();
    tick();
    chk("done_single", done_cnt, 1);
    vals.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_grp_num = '0; cfg_out_num = '0;
    in_valid = 1'b0; out_ready = 1'b1; grp_data = '0;
    model_clear(1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_pipe_en", pipe_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_psum", out_psum, 0);
    rst = 1'b0;
    tick();

    // Single group, single result: latency and done timing.
    vals.push_back(32'd5);
    run_job(1, 1, 1'b0, 1'b0, 0);
    chk("lat1_out_valid", ov_first, fire_first + 4);
    chk("lat1_done", (done_cyc == fire_first + 5) || (done_cyc == fire_first + 6), 1);
    chk("lat1_value", last_res, 32'd5);

    // Three groups per result, two results.
    vals = '{32'd1, 32'd2, 32'd3, 32'd10, 32'd20, 32'd30};
    run_job(3, 2, 1'b0, 1'b0, 0);
    chk("lat3_out_valid", ov_first, fire_first + 6);
    chk("grp3_first", first_res, 32'd6);
    chk("grp3_second", last_res, 32'd60);

    // Output back-pressure for 4 cycles on the first result.
    vals = '{32'd7, 32'd8, 32'd100, 32'd200};
    run_job(2, 2, 1'b0, 1'b0, 4);
    chk("stall_cycles", stall_cyc, 4);
    chk("stall_first", first_res, 32'd15);
    chk("stall_second", last_res, 32'd300);

    // Two's-complement wrap of the accumulator.
    vals = '{32'h7FFF_FFFF, 32'h0000_0002};
    run_job(2, 1, 1'b0, 1'b0, 0);
    chk("wrap_value", last_res, 32'h8000_0001);

    // Zero results: immediate done, no handshake activity.
    run_job(5, 0, 1'b0, 1'b0, 0);
    chk("zero_done_cycle", done_cyc, start_cyc + 1);
    chk("zero_in_ready", inrdy_cnt, 0);
    chk("zero_out_valid", ov_first, -1);

    // Group count of zero behaves as one.
    run_job(0, 3, 1'b1, 1'b1, 0);

    // Reset in the middle of a job.
    model_clear(2);
    start = 1'b1; cfg_grp_num = GW'(2); cfg_out_num = OW'(3);
    tick();
    start = 1'b0; in_valid = 1'b1; grp_data = $urandom; out_ready = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_pipe_en", pipe_en, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_psum", out_psum, 0);
    in_valid = 1'b0;
    done_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", done_cnt, 0);
    vals = '{32'd11, 32'd22, 32'd33, 32'd44};
    run_job(2, 2, 1'b0, 1'b0, 0);
    chk("post_abort_first", first_res, 32'd33);
    chk("post_abort_second", last_res, 32'd77);

    // Randomized jobs against the reference sums.
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(0, 5), $urandom_range(1, 4), 1'b1, 1'b1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
